// File: rtl/cam_ctrl_pkg.sv
// cam_ctrl shared types: command opcodes, response status codes
// and sequencer state encodings.
package cam_ctrl_pkg;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_DUP       = 2'd1,
        ST_FULL      = 2'd2,
        ST_NOT_FOUND = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_WRITE  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/cam_ctrl_if.sv
// Command/response port of cam_ctrl.
// slave: controller side; master: requester side.
interface cam_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_status;
    logic [ADDR_WIDTH-1:0] rsp_addr;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_status, rsp_addr
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_status, rsp_addr
    );
endinterface

// File: rtl/cam_free_alloc.sv
// Occupancy bitmap with lowest-free encoder, full flag and count.
// Ports: set_en/clr_en + idx update one bit; free_idx, full, used_count.
module cam_free_alloc #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] idx,
    output logic [ADDR_WIDTH-1:0] free_idx,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   used_count
);
    localparam int N = 1 << ADDR_WIDTH;

    logic [N-1:0] bitmap;

    // Count only moves when the bit really changes, so it can
    // neither overflow nor underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap     <= '0;
            used_count <= '0;
        end else if (set_en && !bitmap[idx]) begin
            bitmap[idx] <= 1'b1;
            used_count  <= used_count + 1'b1;
        end else if (clr_en && bitmap[idx]) begin
            bitmap[idx] <= 1'b0;
            used_count  <= used_count - 1'b1;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!bitmap[i]) free_idx = ADDR_WIDTH'(i);
        end
    end

    assign full = (used_count == (ADDR_WIDTH + 1)'(N));

endmodule

// File: rtl/cam_ctrl.sv
// Insert/delete sequencer in front of a CAM: search, allocate,
// write, wait busy, respond. Ports: cmd (if), used_count, cam_*.
module cam_ctrl
    import cam_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 9,
    parameter int MATCH_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cam_ctrl_if.slave             cmd,
    output logic [ADDR_WIDTH:0]   used_count,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);
    localparam int CW = $clog2(MATCH_LATENCY + 1);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    status_e               status_q, status_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  set_en, clr_en, full;
    logic [ADDR_WIDTH-1:0] free_idx;

    cam_free_alloc #(.ADDR_WIDTH(ADDR_WIDTH)) u_alloc (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (set_en),
        .clr_en     (clr_en),
        .idx        (addr_q),
        .free_idx   (free_idx),
        .full       (full),
        .used_count (used_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_INSERT;
            status_q <= ST_OK;
            key_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            status_q <= status_d;
            key_q    <= key_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        status_d = status_q;
        key_d    = key_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        set_en   = 1'b0;
        clr_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d    = op_e'(cmd.cmd_op);
                    key_d   = cmd.cmd_data;
                    cnt_d   = CW'(MATCH_LATENCY - 1);
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                // Match result is valid in the last hold cycle only.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (op_q == OP_INSERT) begin
                    if (cam_match) begin
                        status_d = ST_DUP;
                        addr_d   = cam_match_addr;
                        state_d  = S_RESP;
                    end else if (full) begin
                        status_d = ST_FULL;
                        addr_d   = '0;
                        state_d  = S_RESP;
                    end else begin
                        addr_d  = free_idx;
                        state_d = S_WRITE;
                    end
                end else begin
                    if (!cam_match) begin
                        status_d = ST_NOT_FOUND;
                        addr_d   = '0;
                        state_d  = S_RESP;
                    end else begin
                        addr_d  = cam_match_addr;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!cam_write_busy) begin
                    we_d    = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!cam_write_busy) begin
                    set_en   = (op_q == OP_INSERT);
                    clr_en   = (op_q == OP_DELETE);
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (cmd.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd.cmd_ready     = (state_q == S_IDLE);
    assign cmd.rsp_valid     = (state_q == S_RESP);
    assign cmd.rsp_status    = status_q;
    assign cmd.rsp_addr      = addr_q;
    assign cam_compare_data  = key_q;
    assign cam_write_data    = key_q;
    assign cam_write_addr    = addr_q;
    assign cam_write_delete  = (op_q == OP_DELETE);
    assign cam_write_enable  = we_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl with a behavioural CAM
// and a key-table reference model.
module tb_cam_ctrl;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int ML = 2;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW:0]   used_count;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic          cam_write_delete;
    logic          cam_write_enable;
    logic          cam_write_busy;
    logic [DW-1:0] cam_compare_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;
    logic          force_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cam_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cam_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATCH_LATENCY(ML)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd              (bus),
        .used_count       (used_count),
        .cam_write_addr   (cam_write_addr),
        .cam_write_data   (cam_write_data),
        .cam_write_delete (cam_write_delete),
        .cam_write_enable (cam_write_enable),
        .cam_write_busy   (cam_write_busy),
        .cam_compare_data (cam_compare_data),
        .cam_match        (cam_match),
        .cam_match_addr   (cam_match_addr)
    );

    // ---------------- behavioural CAM ----------------
    logic [DW-1:0] c_key [N];
    logic          c_vld [N];
    logic          lk_hit;
    logic [AW-1:0] lk_addr;
    int            busy_cnt;

    always_comb begin
        lk_hit  = 1'b0;
        lk_addr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (c_vld[i] && c_key[i] == cam_compare_data) begin
                lk_hit  = 1'b1;
                lk_addr = AW'(i);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) c_vld[i] <= 1'b0;
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
            busy_cnt       <= 0;
        end else begin
            cam_match      <= lk_hit;
            cam_match_addr <= lk_addr;
            if (cam_write_enable) begin
                c_vld[cam_write_addr] <= !cam_write_delete;
                c_key[cam_write_addr] <= cam_write_data;
                busy_cnt <= int'($urandom_range(0, 3));
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    assign cam_write_busy = (busy_cnt != 0) || force_busy;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_key [N];
    bit            m_vld [N];
    int            m_used = 0;
    logic [1:0]    exp_status;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_key;
    bit            exp_wdel;
    int            exp_wr;
    bit            inflight = 0;

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_vld[i] = 0;
        m_used = 0;
    endtask

    task automatic predict(input bit op, input logic [DW-1:0] key);
        int hit;
        int fr;
        hit = -1;
        fr  = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_vld[i] && m_key[i] == key) hit = i;
            if (!m_vld[i]) fr = i;
        end
        exp_key  = key;
        exp_wdel = op;
        if (!op) begin
            if (hit >= 0) begin
                exp_status = 2'd1; exp_addr = AW'(hit);
            end else if (m_used == N) begin
                exp_status = 2'd2; exp_addr = '0;
            end else begin
                exp_status = 2'd0; exp_addr = AW'(fr);
                m_vld[fr] = 1; m_key[fr] = key; m_used++;
            end
        end else begin
            if (hit < 0) begin
                exp_status = 2'd3; exp_addr = '0;
            end else begin
                exp_status = 2'd0; exp_addr = AW'(hit);
                m_vld[hit] = 0; m_used--;
            end
        end
        exp_wr = (exp_status == 2'd0) ? 1 : 0;
    endtask

    task automatic chk(input string nm, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, req, $time);
        end
    endtask

    // ---------------- compare process ----------------
    int cyc = 0;
    int acc_cyc = 0;
    int en_cyc = 0;
    int wr_pulses = 0;
    bit prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmd_ready", bus.cmd_ready, !inflight);
            if (bus.rsp_valid) begin
                chk("rsp_status", bus.rsp_status, exp_status);
                chk("rsp_addr", bus.rsp_addr, exp_addr);
                chk("used_rsp", used_count, m_used);
                chk("wr_pulses", wr_pulses, exp_wr);
            end else if (!inflight) begin
                chk("used_idle", used_count, m_used);
            end
            if (cam_write_enable) begin
                wr_pulses++;
                en_cyc = cyc;
                chk("wr_while_busy", prev_busy, 0);
                chk("wr_addr", cam_write_addr, exp_addr);
                chk("wr_del", cam_write_delete, exp_wdel);
                chk("wr_data", cam_write_data, exp_key);
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                wr_pulses = 0;
                acc_cyc   = cyc + 1;
            end
            prev_busy = cam_write_busy;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit op, input logic [DW-1:0] key,
                        input int hold,
                        output logic [1:0] st,
                        output logic [AW-1:0] ad);
        bit ok;
        ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = key;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = bus.cmd_ready;
            step();
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
        predict(op, key);
        inflight = 1;
        for (int n = 0; n < 50 && !bus.rsp_valid; n++) step();
        if (!bus.rsp_valid) chk("rsp_timeout", 0, 1);
        repeat (hold) step();
        st = bus.rsp_status;
        ad = bus.rsp_addr;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        inflight = 0;
    endtask

    logic [1:0]    st;
    logic [AW-1:0] ad;
    logic [DW-1:0] fill [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        model_clear();
        repeat (3) step();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_used", used_count, 0);
        chk("rst_we", cam_write_enable, 0);
        chk("rst_cmp", cam_compare_data, 0);
        chk("rst_waddr", cam_write_addr, 0);
        rst_n = 1'b1;
        step();

        send(0, 16'h1111, 0, st, ad);
        chk("ins1_st", st, 0);
        chk("ins1_addr", ad, 0);
        chk("ins1_used", used_count, 1);
        send(0, 16'h2222, 1, st, ad);
        chk("ins2_st", st, 0);
        chk("ins2_addr", ad, 1);
        send(0, 16'h1111, 0, st, ad);
        chk("dup_st", st, 1);
        chk("dup_addr", ad, 0);
        chk("dup_used", used_count, 2);

        for (int i = 0; i < 6; i++) begin
            fill[i] = 16'h3000 + 16'(i);
            send(0, fill[i], 0, st, ad);
        end
        chk("fill_used", used_count, 8);
        send(0, 16'h9999, 0, st, ad);
        chk("full_st", st, 2);
        chk("full_addr", ad, 0);
        send(1, 16'h9999, 0, st, ad);
        chk("nf_st", st, 3);
        chk("nf_addr", ad, 0);

        send(1, fill[1], 0, st, ad);
        chk("del3_st", st, 0);
        chk("del3_addr", ad, 3);
        send(0, 16'hABCD, 5, st, ad);
        chk("hole_st", st, 0);
        chk("hole_addr", ad, 3);
        chk("hole_used", used_count, 8);

        force_busy = 1'b1;
        fork
            begin
                repeat (7) @(posedge clk);
                #1;
                force_busy = 1'b0;
            end
        join_none
        send(1, 16'hABCD, 0, st, ad);
        chk("busy_st", st, 0);
        chk("busy_en_delay", en_cyc - acc_cyc, 7);

        // Reset while the DUT sits in WAIT.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_data  = 16'h5A5A;
        step();
        bus.cmd_valid = 1'b0;
        predict(0, 16'h5A5A);
        inflight = 1;
        repeat (3) step();
        force_busy = 1'b1;
        repeat (2) step();
        chk("pre_rst_rsp", bus.rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.cmd_ready, 1);
        chk("mid_rst_used", used_count, 0);
        chk("mid_rst_rsp", bus.rsp_valid, 0);
        force_busy = 1'b0;
        inflight = 0;
        model_clear();
        step();
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 300; k++) begin
            bit op;
            op = ($urandom_range(0, 99) < 60) ? 1'b0 : 1'b1;
            repeat ($urandom_range(0, 2)) step();
            send(op, 16'h0100 + 16'($urandom_range(0, 11)),
                 int'($urandom_range(0, 3)), st, ad);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
